sdram_chip_model: RTL
=====================

// Module: sdram_chip_model
// PURPOSE
// Cycle-accurate responder for one SDRAM die on the board SDRAM bus; answers sd_* commands from the controller.
// Decodes commands, tracks open rows per bank, holds the mode register, stores data, returns CAS-latency read bursts.
// Flags protocol/timing violations as sticky error bits. Two instances (CHIP_ID 0/1) form the bench memory.
// PARAMETERS
// CHIP_ID   0   sd_cs value this die answers to; other commands ignored (timers still run)
// ROW_BITS  2   low row bits kept in storage; upper row bits aliased
// COL_BITS  10  column bits; storage = 4 * 2**ROW_BITS * 2**COL_BITS x16 words
// T_RCD     1   min cycles ACTIVE->READ/WRITE, same bank
// T_RP      1   min cycles PRECHARGE->ACTIVE/AUTOREF, same bank
// T_RAS     2   min cycles ACTIVE->PRECHARGE, same bank
// T_RFC     3   cycles after AUTOREF in which only NOP is legal
// PORTS
// clk            in   1   clock; sampled with sd_clk = clk
// reset          in   1   synchronous, active-high
// sd_cs          in   1   chip index; selected when == CHIP_ID
// sd_bank        in   2   bank
// sd_addr        in   13  row (ACTIVE), col [COL_BITS-1:0] (READ/WRITE), A10 = all-banks (PRECHARGE), mode (MRS)
// sd_ras/cas/we  in   1   command {ras,cas,we}: 111 NOP,110 STOP,011 ACT,101 RD,100 WR,010 PRE,001 REF,000 MRS
// sd_data_out    in   16  write data from controller
// sd_drive_data  in   1   controller drives bus
// sd_data_in     out  16  read data to controller, 0 when not driving
// rd_valid       out  1   sd_data_in carries burst data this cycle
// err_flags      out  8   sticky violation bits (below)
// refresh_count  out  16  AUTOREF commands accepted, wraps
// BEHAVIOUR
// - Reset: sd_data_in=0, rd_valid=0, err_flags=0, refresh_count=0, all banks closed, read pipeline flushed,
//   mode_set=0, BL=1, CL=2, single-write. Storage contents undefined/retained. Reset mid-burst kills remaining words.
// - Timers: per-bank counters since ACT and PRE, global since REF; saturate at max, start satisfied after reset.
// - ACT: opens bank, latches row. PRE: closes bank (A10=1: all four). REF: refresh_count+1.
// - MRS: BL = sd_addr[2:0] (000=1,001=2,010=4,011=8; other -> 1), CL = sd_addr[6:4] (2 or 3; other -> 2),
//   write burst = ~sd_addr[9]; sets mode_set.
// - Word address = {bank, row[ROW_BITS-1:0], col}; burst column k = {col[hi:log2BL], (col[lo]+k) mod BL}, sequential wrap.
// - READ at cycle T: word k on sd_data_in with rd_valid=1 in cycle T+CL+k, k=0..BL-1; output registered.
//   Implement as a burst generator feeding a CL-deep delay line of {valid, addr}.
// - New READ at T2 restarts generator: old words through T2+CL-1, new burst from T2+CL.
// - STOP, WRITE, PRE (that bank or all) halt generator; entries already in delay line still drive.
// - WRITE at T: stores sd_data_out at burst word 0 in cycle T; if write-burst mode, words 1..BL-1 on following
//   cycles while sd_drive_data=1, aborted by any non-NOP command.
// - Write with sd_drive_data=0 stores nothing. Read data of a word written same cycle = new data.
// - Errors (sticky till reset; command still executed except bit0 access, bit1 ACT which are dropped):
//   [0] RD/WR to closed bank  [1] ACT to open bank  [2] tRCD  [3] tRP  [4] tRAS
//   [5] non-NOP within T_RFC after REF  [6] REF with any bank open  [7] ACT/RD/WR before MRS.
// - Simultaneous: one command per cycle; delay line shift and new write in same cycle both take effect.
// TESTING
// - Init: PRE all, MRS 0x223, REF x2 -> err_flags=0, refresh_count=2, BL=8, CL=2.
// - ACT b1 r3, WR col 0x005 = 0xBEEF, RD col 0x000 at T -> rd_valid T+2..T+9, word at T+7 = 0xBEEF.
// - RD col 0x006 BL8 -> column order 6,7,0,1,2,3,4,5 (wrap in 8-aligned block).
// - RD at T, RD at T+3 -> first burst T+2..T+4, second T+5..T+12, rd_valid never drops.
// - ACT then RD next cycle with T_RCD=2 -> err_flags[2]=1; REF with bank open -> err_flags[6]=1.
// - sd_cs != CHIP_ID WR -> storage unchanged; reset at mid-burst -> rd_valid=0 next cycle, err_flags=0.

Source files
------------

// File: rtl/sdram_chip_model.sv
// Cycle-accurate single-die SDRAM responder: command decode, per-bank row tracking, mode register,
// word storage, CAS-latency read bursts, single/burst writes and sticky protocol-violation flags.
module sdram_chip_model #(
    parameter int CHIP_ID  = 0,
    parameter int ROW_BITS = 2,
    parameter int COL_BITS = 10,
    parameter int T_RCD    = 1,
    parameter int T_RP     = 1,
    parameter int T_RAS    = 2,
    parameter int T_RFC    = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sd_cs,
    input  logic [1:0]  sd_bank,
    input  logic [12:0] sd_addr,
    input  logic        sd_ras,
    input  logic        sd_cas,
    input  logic        sd_we,
    input  logic [15:0] sd_data_out,
    input  logic        sd_drive_data,
    output logic [15:0] sd_data_in,
    output logic        rd_valid,
    output logic [7:0]  err_flags,
    output logic [15:0] refresh_count
);

    localparam int AW    = 2 + ROW_BITS + COL_BITS;
    localparam int DEPTH = 1 << AW;

    localparam logic [3:0] TMAX    = 4'hF;
    localparam logic [3:0] T_RCD_C = 4'(T_RCD);
    localparam logic [3:0] T_RP_C  = 4'(T_RP);
    localparam logic [3:0] T_RAS_C = 4'(T_RAS);
    localparam logic [3:0] T_RFC_C = 4'(T_RFC);

    localparam logic [2:0] CMD_NOP  = 3'b111;
    localparam logic [2:0] CMD_STOP = 3'b110;
    localparam logic [2:0] CMD_ACT  = 3'b011;
    localparam logic [2:0] CMD_RD   = 3'b101;
    localparam logic [2:0] CMD_WR   = 3'b100;
    localparam logic [2:0] CMD_PRE  = 3'b010;
    localparam logic [2:0] CMD_REF  = 3'b001;
    localparam logic [2:0] CMD_MRS  = 3'b000;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == TMAX) ? v : v + 4'd1;
    endfunction

    function automatic logic [2:0] bl_mask_of(input logic [2:0] code);
        logic [2:0] m;
        case (code)
            3'b000:  m = 3'd0;
            3'b001:  m = 3'd1;
            3'b010:  m = 3'd3;
            3'b011:  m = 3'd7;
            default: m = 3'd0;
        endcase
        return m;
    endfunction

    // Sequential wrap: only the low log2(BL) column bits advance.
    function automatic logic [AW-1:0] burst_addr(input logic [AW-1:0] base, input logic [2:0] k,
                                                 input logic [2:0] mask);
        logic [2:0] lo;
        lo = (base[2:0] & ~mask) | ((base[2:0] + k) & mask);
        return {base[AW-1:3], lo};
    endfunction

    logic [15:0]         mem_r [DEPTH];
    logic [3:0]          open_r;
    logic [ROW_BITS-1:0] row_r [4];
    logic [3:0]          act_cnt_r [4];
    logic [3:0]          pre_cnt_r [4];
    logic [3:0]          ref_cnt_r;
    logic                mode_set_r;
    logic [2:0]          bl_mask_r;
    logic                cl3_r;
    logic                wburst_r;
    logic                gen_active_r, wgen_active_r;
    logic [2:0]          gen_k_r, wgen_k_r;
    logic [AW-1:0]       gen_addr_r, wgen_addr_r;
    logic                dl_valid_r [3];
    logic [AW-1:0]       dl_addr_r [3];

    logic [2:0]    cmd_s;
    logic          sel_s, cmd_any_s, bank_open_s;
    logic          is_act_s, is_rd_s, is_wr_s, is_pre_s, is_ref_s, is_mrs_s, is_stop_s;
    logic          act_ok_s, rd_ok_s, wr_ok_s, halt_s;
    logic [3:0]    pre_mask_s;
    logic [AW-1:0] cmd_addr_s;
    logic          pre_tras_s, trp_any_s;
    logic [7:0]    err_set_s;
    logic          ent_valid_s, gen_active_n, wgen_active_n;
    logic [AW-1:0] ent_addr_s, gen_addr_n, wgen_addr_n;
    logic [2:0]    gen_k_n, wgen_k_n;
    logic          mem_we_s;
    logic [AW-1:0] mem_waddr_s;
    logic [15:0]   mem_wdata_s;
    logic          tap_valid_s;
    logic [AW-1:0] tap_addr_s;
    logic [15:0]   rd_data_s;
    logic          unused_s;

    assign unused_s    = ^sd_addr[12:11];
    assign cmd_s       = {sd_ras, sd_cas, sd_we};
    assign sel_s       = (sd_cs == 1'(CHIP_ID));
    assign cmd_any_s   = sel_s && (cmd_s != CMD_NOP);
    assign is_act_s    = sel_s && (cmd_s == CMD_ACT);
    assign is_rd_s     = sel_s && (cmd_s == CMD_RD);
    assign is_wr_s     = sel_s && (cmd_s == CMD_WR);
    assign is_pre_s    = sel_s && (cmd_s == CMD_PRE);
    assign is_ref_s    = sel_s && (cmd_s == CMD_REF);
    assign is_mrs_s    = sel_s && (cmd_s == CMD_MRS);
    assign is_stop_s   = sel_s && (cmd_s == CMD_STOP);
    assign bank_open_s = open_r[sd_bank];
    assign act_ok_s    = is_act_s && !bank_open_s;
    assign rd_ok_s     = is_rd_s && bank_open_s;
    assign wr_ok_s     = is_wr_s && bank_open_s;
    assign cmd_addr_s  = {sd_bank, row_r[sd_bank], sd_addr[COL_BITS-1:0]};
    assign pre_mask_s  = is_pre_s ? (sd_addr[10] ? 4'b1111 : (4'b0001 << sd_bank)) : 4'b0000;
    assign halt_s      = is_stop_s || is_wr_s ||
                         (is_pre_s && (sd_addr[10] || (gen_addr_r[AW-1 -: 2] == sd_bank)));

    // Per-bank timing checks that depend on more than the addressed bank.
    always_comb begin
        pre_tras_s = 1'b0;
        trp_any_s  = 1'b0;
        for (int b = 0; b < 4; b++) begin
            pre_tras_s = pre_tras_s | (pre_mask_s[b] & open_r[b] & (act_cnt_r[b] < T_RAS_C));
            trp_any_s  = trp_any_s | (pre_cnt_r[b] < T_RP_C);
        end
    end

    assign err_set_s[0] = (is_rd_s || is_wr_s) && !bank_open_s;
    assign err_set_s[1] = is_act_s && bank_open_s;
    assign err_set_s[2] = (rd_ok_s || wr_ok_s) && (act_cnt_r[sd_bank] < T_RCD_C);
    assign err_set_s[3] = (is_act_s && (pre_cnt_r[sd_bank] < T_RP_C)) || (is_ref_s && trp_any_s);
    assign err_set_s[4] = pre_tras_s;
    assign err_set_s[5] = cmd_any_s && (ref_cnt_r <= T_RFC_C);
    assign err_set_s[6] = is_ref_s && (|open_r);
    assign err_set_s[7] = (is_act_s || is_rd_s || is_wr_s) && !mode_set_r;

    // Read burst generator: a new READ restarts it, halting commands cut it off this cycle.
    always_comb begin
        ent_valid_s  = 1'b0;
        ent_addr_s   = cmd_addr_s;
        gen_active_n = 1'b0;
        gen_k_n      = gen_k_r;
        gen_addr_n   = gen_addr_r;
        if (rd_ok_s) begin
            ent_valid_s  = 1'b1;
            gen_active_n = (bl_mask_r != 3'd0);
            gen_k_n      = 3'd1;
            gen_addr_n   = cmd_addr_s;
        end else if (gen_active_r && !halt_s) begin
            ent_valid_s  = 1'b1;
            ent_addr_s   = burst_addr(gen_addr_r, gen_k_r, bl_mask_r);
            gen_active_n = (gen_k_r != bl_mask_r);
            gen_k_n      = gen_k_r + 3'd1;
        end else begin
            ent_valid_s  = 1'b0;
            gen_active_n = 1'b0;
        end
    end

    // Write path: word 0 with the command, later words only on NOP cycles with the bus driven.
    always_comb begin
        mem_we_s      = 1'b0;
        mem_waddr_s   = cmd_addr_s;
        mem_wdata_s   = sd_data_out;
        wgen_active_n = 1'b0;
        wgen_k_n      = wgen_k_r;
        wgen_addr_n   = wgen_addr_r;
        if (wr_ok_s) begin
            mem_we_s      = sd_drive_data;
            wgen_active_n = wburst_r && (bl_mask_r != 3'd0);
            wgen_k_n      = 3'd1;
            wgen_addr_n   = cmd_addr_s;
        end else if (wgen_active_r && !cmd_any_s && sd_drive_data) begin
            mem_we_s      = 1'b1;
            mem_waddr_s   = burst_addr(wgen_addr_r, wgen_k_r, bl_mask_r);
            wgen_active_n = (wgen_k_r != bl_mask_r);
            wgen_k_n      = wgen_k_r + 3'd1;
        end else begin
            wgen_active_n = 1'b0;
        end
    end

    // Output tap: the registered output stage supplies the last cycle of latency.
    always_comb begin
        tap_valid_s = cl3_r ? dl_valid_r[2] : dl_valid_r[1];
        tap_addr_s  = cl3_r ? dl_addr_r[2] : dl_addr_r[1];
        if (mem_we_s && (mem_waddr_s == tap_addr_s)) begin
            rd_data_s = mem_wdata_s;
        end else begin
            rd_data_s = mem_r[tap_addr_s];
        end
    end

    // Storage array; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we_s && !reset) begin
            mem_r[mem_waddr_s] <= mem_wdata_s;
        end
    end

    // Bank state, timers, mode register, pipelines, flags and outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            open_r        <= 4'b0000;
            ref_cnt_r     <= TMAX;
            mode_set_r    <= 1'b0;
            bl_mask_r     <= 3'd0;
            cl3_r         <= 1'b0;
            wburst_r      <= 1'b0;
            gen_active_r  <= 1'b0;
            gen_k_r       <= 3'd0;
            gen_addr_r    <= '0;
            wgen_active_r <= 1'b0;
            wgen_k_r      <= 3'd0;
            wgen_addr_r   <= '0;
            err_flags     <= 8'h00;
            refresh_count <= 16'h0000;
            rd_valid      <= 1'b0;
            sd_data_in    <= 16'h0000;
            for (int b = 0; b < 4; b++) begin
                row_r[b]     <= '0;
                act_cnt_r[b] <= TMAX;
                pre_cnt_r[b] <= TMAX;
            end
            for (int i = 0; i < 3; i++) begin
                dl_valid_r[i] <= 1'b0;
                dl_addr_r[i]  <= '0;
            end
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (act_ok_s && (sd_bank == 2'(b))) begin
                    open_r[b]    <= 1'b1;
                    row_r[b]     <= sd_addr[ROW_BITS-1:0];
                    act_cnt_r[b] <= 4'd1;
                end else begin
                    if (pre_mask_s[b]) begin
                        open_r[b] <= 1'b0;
                    end
                    act_cnt_r[b] <= sat_inc(act_cnt_r[b]);
                end
                pre_cnt_r[b] <= pre_mask_s[b] ? 4'd1 : sat_inc(pre_cnt_r[b]);
            end
            ref_cnt_r <= is_ref_s ? 4'd1 : sat_inc(ref_cnt_r);
            if (is_ref_s) begin
                refresh_count <= refresh_count + 16'd1;
            end
            if (is_mrs_s) begin
                mode_set_r <= 1'b1;
                bl_mask_r  <= bl_mask_of(sd_addr[2:0]);
                cl3_r      <= (sd_addr[6:4] == 3'd3);
                wburst_r   <= ~sd_addr[9];
            end
            gen_active_r  <= gen_active_n;
            gen_k_r       <= gen_k_n;
            gen_addr_r    <= gen_addr_n;
            wgen_active_r <= wgen_active_n;
            wgen_k_r      <= wgen_k_n;
            wgen_addr_r   <= wgen_addr_n;
            dl_valid_r[0] <= ent_valid_s;
            dl_addr_r[0]  <= ent_addr_s;
            for (int i = 1; i < 3; i++) begin
                dl_valid_r[i] <= dl_valid_r[i-1];
                dl_addr_r[i]  <= dl_addr_r[i-1];
            end
            err_flags  <= err_flags | err_set_s;
            rd_valid   <= tap_valid_s;
            sd_data_in <= tap_valid_s ? rd_data_s : 16'h0000;
        end
    end

endmodule
